// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit sequencer.
// Holds the MDU operation codes, the FSM state encoding and small decode
// helpers so the arithmetic block, the controller and the bench all agree
// on the same encodings.
package mdu_ctrl_pkg;

    // E-stage MDU operation codes; code 7 is unused and behaves as MD_NONE.
    typedef enum logic [2:0] {
        MD_NONE  = 3'd0,
        MD_MULT  = 3'd1,
        MD_MULTU = 3'd2,
        MD_DIV   = 3'd3,
        MD_DIVU  = 3'd4,
        MD_MTHI  = 3'd5,
        MD_MTLO  = 3'd6
    } md_op_e;

    typedef enum logic {
        MDU_IDLE = 1'b0,
        MDU_RUN  = 1'b1
    } mdu_state_e;

    // Multi-cycle operations: the ones that occupy the unit and write HI/LO later.
    function automatic logic is_long_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU) || (op == MD_DIV) || (op == MD_DIVU);
    endfunction

    function automatic logic is_mult_op(input logic [2:0] op);
        return (op == MD_MULT) || (op == MD_MULTU);
    endfunction

endpackage

// File: rtl/mdu_ctrl_if.sv
// Bundle between the E/D pipeline stages and the MDU sequencer.
//   md_op, rs_val, rt_val : E-stage operation and forwarded operands
//   d_md_use              : D-stage instruction touches the MDU
//   hi, lo                : architectural HI/LO registers
//   busy, md_stall        : operation in flight / stall request for D
// master = pipeline side, slave = MDU side.
interface mdu_ctrl_if;
    logic [2:0]  md_op;
    logic [31:0] rs_val;
    logic [31:0] rt_val;
    logic        d_md_use;
    logic [31:0] hi;
    logic [31:0] lo;
    logic        busy;
    logic        md_stall;

    modport master (
        output md_op, rs_val, rt_val, d_md_use,
        input  hi, lo, busy, md_stall
    );

    modport slave (
        input  md_op, rs_val, rt_val, d_md_use,
        output hi, lo, busy, md_stall
    );
endinterface

// File: rtl/mdu_ctrl_arith.sv
// Combinational MDU datapath: computes the 64-bit {hi,lo} result of
// mult/multu/div/divu in one shot; the controller models the latency.
//   op     : operation code (non-arithmetic codes give wr_en=0)
//   a, b   : rs / rt operands
//   res_hi, res_lo : result halves
//   wr_en  : result should be written (0 for divide-by-zero)
module mdu_ctrl_arith
    import mdu_ctrl_pkg::*;
(
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] res_hi,
    output logic [31:0] res_lo,
    output logic        wr_en
);
    logic [63:0] prod_s;
    logic [63:0] prod_u;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] dvd;
    logic [31:0] dvs;
    logic [31:0] quo;
    logic [31:0] rem;

    always_comb begin
        // NOTE: every output and temporary gets a value before the case so
        // no path through this block leaves a latch behind.
        res_hi = '0;
        res_lo = '0;
        wr_en  = 1'b0;

        // Low 64 bits of the product of sign-extended operands equal the
        // signed product, so one plain multiplier form serves both cases.
        prod_s = {{32{a[31]}}, a} * {{32{b[31]}}, b};
        prod_u = {32'd0, a} * {32'd0, b};

        // Signed divide runs on magnitudes; the magnitude of 0x80000000 is
        // 0x80000000 read as unsigned, which makes the overflow case
        // 0x80000000 / -1 come out as quotient 0x80000000, remainder 0.
        a_mag = a[31] ? (~a + 32'd1) : a;
        b_mag = b[31] ? (~b + 32'd1) : b;
        dvd   = (op == MD_DIV) ? a_mag : a;
        dvs   = (op == MD_DIV) ? b_mag : b;
        // Divisor forced to 1 on zero: the result is discarded anyway.
        quo   = dvd / ((dvs == 32'd0) ? 32'd1 : dvs);
        rem   = dvd % ((dvs == 32'd0) ? 32'd1 : dvs);

        case (op)
            MD_MULT: begin
                {res_hi, res_lo} = prod_s;
                wr_en = 1'b1;
            end
            MD_MULTU: begin
                {res_hi, res_lo} = prod_u;
                wr_en = 1'b1;
            end
            MD_DIV: begin
                res_lo = (a[31] ^ b[31]) ? (~quo + 32'd1) : quo;
                res_hi = a[31] ? (~rem + 32'd1) : rem;
                wr_en  = (b != 32'd0);
            end
            MD_DIVU: begin
                res_lo = quo;
                res_hi = rem;
                wr_en  = (b != 32'd0);
            end
            default: ;
        endcase
    end
endmodule

// File: rtl/mdu_ctrl.sv
// MDU sequencer for the E stage: accepts MDU ops, holds the unit busy for
// MULT_CYCLES / DIV_CYCLES, owns HI/LO and raises the D-stage stall.
//   clk   : system clock, rising edge
//   reset : synchronous, active-high
//   bus   : mdu_ctrl_if.slave (op/operands in, hi/lo/busy/md_stall out)
module mdu_ctrl
    import mdu_ctrl_pkg::*;
#(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10,
    parameter int CNT_W       = 4
) (
    input  logic        clk,
    input  logic        reset,
    mdu_ctrl_if.slave   bus
);
    mdu_state_e         state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        pend_hi_q, pend_hi_d;
    logic [31:0]        pend_lo_q, pend_lo_d;
    logic               pend_wr_q, pend_wr_d;
    logic [31:0]        hi_q, hi_d;
    logic [31:0]        lo_q, lo_d;

    logic [31:0]        arith_hi;
    logic [31:0]        arith_lo;
    logic               arith_wr;
    logic               busy;

    mdu_ctrl_arith u_arith (
        .op     (bus.md_op),
        .a      (bus.rs_val),
        .b      (bus.rt_val),
        .res_hi (arith_hi),
        .res_lo (arith_lo),
        .wr_en  (arith_wr)
    );

    // State register.
    always_ff @(posedge clk) begin
        // NOTE: sequential state uses non-blocking assignments so every flop
        // samples the pre-edge value regardless of statement order.
        if (reset) begin
            state_q   <= MDU_IDLE;
            cnt_q     <= '0;
            pend_hi_q <= '0;
            pend_lo_q <= '0;
            pend_wr_q <= 1'b0;
            hi_q      <= '0;
            lo_q      <= '0;
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            pend_hi_q <= pend_hi_d;
            pend_lo_q <= pend_lo_d;
            pend_wr_q <= pend_wr_d;
            hi_q      <= hi_d;
            lo_q      <= lo_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        pend_hi_d = pend_hi_q;
        pend_lo_d = pend_lo_q;
        pend_wr_d = pend_wr_q;
        hi_d      = hi_q;
        lo_d      = lo_q;

        case (state_q)
            MDU_IDLE: begin
                if (is_long_op(bus.md_op)) begin
                    pend_hi_d = arith_hi;
                    pend_lo_d = arith_lo;
                    pend_wr_d = arith_wr;
                    cnt_d     = is_mult_op(bus.md_op) ? CNT_W'(MULT_CYCLES)
                                                      : CNT_W'(DIV_CYCLES);
                    state_d   = MDU_RUN;
                end else if (bus.md_op == MD_MTHI) begin
                    hi_d = bus.rs_val;
                end else if (bus.md_op == MD_MTLO) begin
                    lo_d = bus.rs_val;
                end
            end
            MDU_RUN: begin
                // md_op is ignored here; the hazard unit never issues into RUN.
                if (cnt_q <= CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = MDU_IDLE;
                    if (pend_wr_q) begin
                        hi_d = pend_hi_q;
                        lo_d = pend_lo_q;
                    end
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            default: state_d = MDU_IDLE;
        endcase
    end

    // Outputs. The stall also covers the issue cycle so a D-stage mfhi/mflo
    // never sees HI/LO before the new result lands.
    always_comb begin
        busy         = (state_q == MDU_RUN);
        bus.busy     = busy;
        bus.md_stall = bus.d_md_use & (busy | is_long_op(bus.md_op));
        bus.hi       = hi_q;
        bus.lo       = lo_q;
    end
endmodule

// File: doc/mdu_ctrl.md
Name: mdu_ctrl

Overview:
Multiply/divide unit sequencer for the P6 pipelined MIPS core, sitting in the E stage beside the ALU.
- Accepts mult/multu/div/divu/mthi/mtlo issued from E.
- Models the multi-cycle latency with a busy counter and owns the HI/LO registers.
- Emits the stall request that holds any MDU-using instruction in D while an operation is pending.

Parameters:
MULT_CYCLES, 5, busy cycles for mult/multu (>=1)
DIV_CYCLES, 10, busy cycles for div/divu (>=1)
CNT_W, 4, counter width; must hold max(MULT_CYCLES, DIV_CYCLES)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  synchronous, active-high
md_op  in  3  E-stage MDU op; MD_NONE when idle
rs_val  in  32  forwarded rs operand (E stage)
rt_val  in  32  forwarded rt operand (E stage)
d_md_use  in  1  D-stage instr is mult/multu/div/divu/mthi/mtlo/mfhi/mflo
hi  out  32  HI register
lo  out  32  LO register
busy  out  1  operation in flight
md_stall  out  1  stall request to hazard unit

Behaviour:
- Reset (sync, active-high): hi=0, lo=0, busy=0, counter=0, pending result=0, state IDLE.
  - Reset mid-operation aborts the operation; HI/LO are not written.
- States: IDLE, RUN.
- IDLE, md_op in {MULT, MULTU, DIV, DIVU} at edge k:
  - Latch the 64-bit result from mdu_arith(rs_val, rt_val) into pending_hi/pending_lo.
  - Load counter = MULT_CYCLES or DIV_CYCLES; go to RUN.
- RUN:
  - busy=1 during cycles k+1 .. k+N, N = loaded count.
  - Counter decrements each edge.
  - At the edge ending cycle k+N (counter==1): write hi/lo from pending, counter=0, go IDLE.
  - New hi/lo and busy=0 are both visible from cycle k+N+1.
- IDLE, md_op=MTHI: hi<=rs_val at edge k, visible k+1. MTLO: lo<=rs_val likewise. No busy, no counter change.
- md_op ignored while RUN (hazard unit guarantees this cannot occur); state and pending result unchanged.
- Unknown md_op codes are treated as MD_NONE.
- md_stall = d_md_use & (busy | md_op is MULT/MULTU/DIV/DIVU).
  - Purely combinational.
  - Covers the issue cycle, so a D-stage mfhi/mflo never reads stale HI/LO.
  - mthi/mtlo in E does not stall D; E-to-D HI/LO forwarding is not provided, so D reads hi/lo registers only after write.
- Arithmetic (mdu_arith):
  - MULT: signed 32x32->64, {hi,lo}=product.
  - MULTU: unsigned 32x32->64, {hi,lo}=product.
  - DIV: signed; lo=quotient truncated toward zero, hi=remainder with sign of dividend.
  - DIVU: unsigned quotient/remainder.
- Boundaries:
  - Divide by zero (rt_val==0, div or divu): full DIV_CYCLES busy; hi/lo unchanged at completion (write suppressed).
  - DIV 0x80000000 / 0xFFFFFFFF: lo=0x80000000, hi=0.
  - Back-to-back: a new op is accepted in the cycle where busy has just fallen (k+N+1).

Decomposition:
- Shared header MDU_DEF.v: `define constants.
  - MD_NONE=3'd0, MD_MULT=3'd1, MD_MULTU=3'd2, MD_DIV=3'd3, MD_DIVU=3'd4, MD_MTHI=3'd5, MD_MTLO=3'd6.
  - State encodings MDU_IDLE=1'b0, MDU_RUN=1'b1.
- Decoder/controller include the same header so encodings stay consistent.
- One combinational sub-module, mdu_arith:
  - Inputs: op, a, b.
  - Outputs: res_hi, res_lo, wr_en (0 for divide-by-zero).
- mdu_ctrl holds the FSM, counter, pending registers, HI/LO and the stall logic.

Test Plan:
- MULT rs=0xFFFFFFFD(-3), rt=5 at cycle 1:
  - busy=1 in cycles 2-6.
  - hi=0xFFFFFFFF, lo=0xFFFFFFF1 and busy=0 from cycle 7.
- MULTU rs=0xFFFFFFFF, rt=2 -> after 5 busy cycles hi=0x00000001, lo=0xFFFFFFFE.
- DIV rs=0xFFFFFFF9(-7), rt=2 -> busy 10 cycles; lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- Divide by zero: preload via MTHI 0x1234 then MTLO 0x5678 (each visible next cycle); DIVU rs=7, rt=0:
  - busy 10 cycles.
  - hi=0x1234, lo=0x5678 afterwards.
- Stall: d_md_use=1 held during the issue cycle and all busy cycles:
  - md_stall=1 from issue cycle through k+N.
  - md_stall=0 at k+N+1.
  - d_md_use=0 -> md_stall=0 throughout.
- Reset mid-operation: DIV issued, reset asserted in the 3rd busy cycle:
  - Next cycle busy=0, hi=0, lo=0.
  - A following MULT 2x3 completes normally with lo=6, hi=0.
